// File: rtl/ldpc_iter_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ldpc_iter_ctrl                                                |
// | Description : Iteration sequencer for one LDPC decode over the 6x6 PE       |
// |               array. Walks LOAD -> (CNU -> VNU -> TEST)* -> OUTPUT -> DONE, |
// |               stopping on a clean syndrome or at the iteration limit.       |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module ldpc_iter_ctrl #(
    parameter int MAX_ITER    = 10,
    parameter int ITER_W      = 4,
    parameter int LOAD_CYCLES = 6,
    parameter int CNU_LAT     = 2,
    parameter int VNU_LAT     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ITER_W-1:0] max_iter_cfg,
    input  logic              chk_valid,
    input  logic              syndrome_ok,
    output logic              busy,
    output logic              load_en,
    output logic [2:0]        load_col,
    output logic              cnu_en,
    output logic              pe_update_en,
    output logic              out_en,
    output logic              done,
    output logic              converged,
    output logic [ITER_W-1:0] iter_cnt
);

    // Phase counter spans the longest timed phase; never narrower than load_col
    // so the next column index can be taken straight from the incremented count.
    localparam int c_ph_max_a = (LOAD_CYCLES > CNU_LAT) ? LOAD_CYCLES : CNU_LAT;
    localparam int c_ph_max   = (c_ph_max_a > VNU_LAT) ? c_ph_max_a : VNU_LAT;
    localparam int c_ph_bits  = $clog2(c_ph_max + 1);
    localparam int c_ph_w     = (c_ph_bits > 3) ? c_ph_bits : 3;

    localparam logic [c_ph_w-1:0] c_load_last = c_ph_w'(LOAD_CYCLES - 1);
    localparam logic [c_ph_w-1:0] c_cnu_last  = c_ph_w'(CNU_LAT - 1);
    localparam logic [c_ph_w-1:0] c_vnu_last  = c_ph_w'(VNU_LAT - 1);
    localparam logic [ITER_W-1:0] c_def_limit = ITER_W'(MAX_ITER);

    // State encoding
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_load   = 3'd1;
    localparam logic [2:0] c_st_cnu    = 3'd2;
    localparam logic [2:0] c_st_vnu    = 3'd3;
    localparam logic [2:0] c_st_test   = 3'd4;
    localparam logic [2:0] c_st_output = 3'd5;
    localparam logic [2:0] c_st_done   = 3'd6;

    logic [2:0]        r_state;
    logic [c_ph_w-1:0] r_phase;
    logic [ITER_W-1:0] r_limit;
    logic [ITER_W-1:0] r_iter_cnt;
    logic              r_converged;
    logic              r_busy;
    logic              r_load_en;
    logic [2:0]        r_load_col;
    logic              r_cnu_en;
    logic              r_pe_update_en;
    logic              r_out_en;
    logic              r_done;

    logic [c_ph_w-1:0] w_phase_inc;
    logic [ITER_W-1:0] w_iter_inc;

    assign w_phase_inc = r_phase + 1'b1;
    assign w_iter_inc  = r_iter_cnt + 1'b1;

    // Sequencer: state, phase counter and every output strobe are registered
    // together, so each output is set for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_st_idle;
            r_phase        <= '0;
            r_limit        <= '0;
            r_iter_cnt     <= '0;
            r_converged    <= 1'b0;
            r_busy         <= 1'b0;
            r_load_en      <= 1'b0;
            r_load_col     <= 3'd0;
            r_cnu_en       <= 1'b0;
            r_pe_update_en <= 1'b0;
            r_out_en       <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state     <= c_st_load;
                        r_phase     <= '0;
                        r_limit     <= (max_iter_cfg == '0) ? c_def_limit : max_iter_cfg;
                        r_iter_cnt  <= '0;
                        r_converged <= 1'b0;
                        r_busy      <= 1'b1;
                        r_load_en   <= 1'b1;
                        r_load_col  <= 3'd0;
                    end
                end

                c_st_load: begin
                    if (r_phase == c_load_last) begin
                        r_state    <= c_st_cnu;
                        r_phase    <= '0;
                        r_load_en  <= 1'b0;
                        r_load_col <= 3'd0;
                        r_cnu_en   <= 1'b1;
                    end else begin
                        r_phase    <= w_phase_inc;
                        r_load_col <= w_phase_inc[2:0];
                    end
                end

                c_st_cnu: begin
                    if (r_phase == c_cnu_last) begin
                        r_state        <= c_st_vnu;
                        r_phase        <= '0;
                        r_cnu_en       <= 1'b0;
                        r_pe_update_en <= 1'b1;
                    end else begin
                        r_phase <= w_phase_inc;
                    end
                end

                c_st_vnu: begin
                    if (r_phase == c_vnu_last) begin
                        r_state        <= c_st_test;
                        r_phase        <= '0;
                        r_pe_update_en <= 1'b0;
                        // The limit check in TEST stops the count before it can wrap.
                        r_iter_cnt     <= w_iter_inc;
                    end else begin
                        r_phase <= w_phase_inc;
                    end
                end

                c_st_test: begin
                    // Hold here until the syndrome checker reports; a clean
                    // syndrome wins even on the final allowed iteration.
                    if (chk_valid) begin
                        r_phase <= '0;
                        if (syndrome_ok) begin
                            r_state     <= c_st_output;
                            r_converged <= 1'b1;
                            r_out_en    <= 1'b1;
                        end else if (r_iter_cnt >= r_limit) begin
                            r_state  <= c_st_output;
                            r_out_en <= 1'b1;
                        end else begin
                            r_state  <= c_st_cnu;
                            r_cnu_en <= 1'b1;
                        end
                    end
                end

                c_st_output: begin
                    r_state  <= c_st_done;
                    r_phase  <= '0;
                    r_out_en <= 1'b0;
                    r_done   <= 1'b1;
                end

                c_st_done: begin
                    // start is not looked at here; it is only honoured from IDLE.
                    r_state <= c_st_idle;
                    r_phase <= '0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state        <= c_st_idle;
                    r_phase        <= '0;
                    r_busy         <= 1'b0;
                    r_load_en      <= 1'b0;
                    r_load_col     <= 3'd0;
                    r_cnu_en       <= 1'b0;
                    r_pe_update_en <= 1'b0;
                    r_out_en       <= 1'b0;
                    r_done         <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign load_en      = r_load_en;
    assign load_col     = r_load_col;
    assign cnu_en       = r_cnu_en;
    assign pe_update_en = r_pe_update_en;
    assign out_en       = r_out_en;
    assign done         = r_done;
    assign converged    = r_converged;
    assign iter_cnt     = r_iter_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ldpc_iter_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ldpc_iter_ctrl                                             |
// | Description : Directed bench for ldpc_iter_ctrl with default parameters.    |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_ldpc_iter_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] max_iter_cfg;
    logic       chk_valid;
    logic       syndrome_ok;
    logic       busy;
    logic       load_en;
    logic [2:0] load_col;
    logic       cnu_en;
    logic       pe_update_en;
    logic       out_en;
    logic       done;
    logic       converged;
    logic [3:0] iter_cnt;

    int errors = 0;
    int checks = 0;

    ldpc_iter_ctrl #(
        .MAX_ITER    (10),
        .ITER_W      (4),
        .LOAD_CYCLES (6),
        .CNU_LAT     (2),
        .VNU_LAT     (2)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .max_iter_cfg (max_iter_cfg),
        .chk_valid    (chk_valid),
        .syndrome_ok  (syndrome_ok),
        .busy         (busy),
        .load_en      (load_en),
        .load_col     (load_col),
        .cnu_en       (cnu_en),
        .pe_update_en (pe_update_en),
        .out_en       (out_en),
        .done         (done),
        .converged    (converged),
        .iter_cnt     (iter_cnt)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
        chk({tag, ".load_en"}, {31'd0, load_en}, 32'd0);
        chk({tag, ".load_col"}, {29'd0, load_col}, 32'd0);
        chk({tag, ".cnu_en"}, {31'd0, cnu_en}, 32'd0);
        chk({tag, ".pe_update_en"}, {31'd0, pe_update_en}, 32'd0);
        chk({tag, ".out_en"}, {31'd0, out_en}, 32'd0);
        chk({tag, ".done"}, {31'd0, done}, 32'd0);
        chk({tag, ".converged"}, {31'd0, converged}, 32'd0);
        chk({tag, ".iter_cnt"}, {28'd0, iter_cnt}, 32'd0);
    endtask

    // Six LOAD cycles, column i on cycle i, no other strobe active.
    task automatic expect_load(input string tag);
        for (int i = 0; i < 6; i++) begin
            chk({tag, ".load_en"}, {31'd0, load_en}, 32'd1);
            chk({tag, ".load_col"}, {29'd0, load_col}, i);
            chk({tag, ".cnu_en_in_load"}, {31'd0, cnu_en}, 32'd0);
            chk({tag, ".pe_in_load"}, {31'd0, pe_update_en}, 32'd0);
            chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
            cyc();
        end
    endtask

    // One CNU burst and one VNU burst, ending in TEST with iter_cnt == it.
    // With noise set, start and a clean syndrome are waved during CNU.
    task automatic expect_iter(input string tag, input int it, input bit noise);
        for (int i = 0; i < 2; i++) begin
            chk({tag, ".cnu_en"}, {31'd0, cnu_en}, 32'd1);
            chk({tag, ".load_in_cnu"}, {31'd0, load_en}, 32'd0);
            chk({tag, ".pe_in_cnu"}, {31'd0, pe_update_en}, 32'd0);
            if (noise) begin
                start       = 1'b1;
                chk_valid   = 1'b1;
                syndrome_ok = 1'b1;
            end
            cyc();
        end
        start       = 1'b0;
        chk_valid   = 1'b0;
        syndrome_ok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk({tag, ".pe_update_en"}, {31'd0, pe_update_en}, 32'd1);
            chk({tag, ".cnu_in_vnu"}, {31'd0, cnu_en}, 32'd0);
            cyc();
        end
        chk({tag, ".test_iter_cnt"}, {28'd0, iter_cnt}, it);
        chk({tag, ".test_cnu"}, {31'd0, cnu_en}, 32'd0);
        chk({tag, ".test_pe"}, {31'd0, pe_update_en}, 32'd0);
        chk({tag, ".test_busy"}, {31'd0, busy}, 32'd1);
    endtask

    // Present one syndrome result in TEST and advance.
    task automatic report(input bit ok);
        chk_valid   = 1'b1;
        syndrome_ok = ok;
        cyc();
        chk_valid   = 1'b0;
        syndrome_ok = 1'b0;
    endtask

    task automatic begin_decode(input logic [3:0] cfg);
        max_iter_cfg = cfg;
        start        = 1'b1;
        cyc();
        start        = 1'b0;
    endtask

    // OUTPUT then DONE then IDLE, with the final status held.
    task automatic expect_finish(input string tag, input bit conv, input int it);
        chk({tag, ".out_en"}, {31'd0, out_en}, 32'd1);
        chk({tag, ".done_early"}, {31'd0, done}, 32'd0);
        chk({tag, ".cnu_after_test"}, {31'd0, cnu_en}, 32'd0);
        chk({tag, ".converged"}, {31'd0, converged}, conv);
        start = 1'b1;
        cyc();
        chk({tag, ".done"}, {31'd0, done}, 32'd1);
        chk({tag, ".out_en_one_cycle"}, {31'd0, out_en}, 32'd0);
        chk({tag, ".iter_cnt"}, {28'd0, iter_cnt}, it);
        cyc();
        start = 1'b0;
        chk({tag, ".done_one_cycle"}, {31'd0, done}, 32'd0);
        chk({tag, ".idle_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, ".held_converged"}, {31'd0, converged}, conv);
        chk({tag, ".held_iter_cnt"}, {28'd0, iter_cnt}, it);
        cyc();
        chk({tag, ".start_not_queued"}, {31'd0, busy}, 32'd0);
        chk({tag, ".no_load_after"}, {31'd0, load_en}, 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        max_iter_cfg = 4'd0;
        chk_valid    = 1'b0;
        syndrome_ok  = 1'b0;
        cyc();
        cyc();
        chk_all_zero("reset");
        rst = 1'b0;
        cyc();
        chk_all_zero("idle");

        // Reset while in VNU of iteration 2, then a clean restart.
        begin_decode(4'd0);
        expect_load("rst_load");
        expect_iter("rst_it1", 1, 1'b0);
        report(1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("rst_it2.cnu_en", {31'd0, cnu_en}, 32'd1);
            cyc();
        end
        chk("rst_it2.pe_update_en", {31'd0, pe_update_en}, 32'd1);
        rst = 1'b1;
        cyc();
        chk_all_zero("mid_vnu_rst");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("post_rst.done", {31'd0, done}, 32'd0);
            chk("post_rst.busy", {31'd0, busy}, 32'd0);
        end

        // Early convergence on the first TEST cycle.
        begin_decode(4'd0);
        expect_load("conv_load");
        expect_iter("conv_it1", 1, 1'b0);
        report(1'b1);
        expect_finish("conv", 1'b1, 1);

        // Limit of 3, never converging; cfg changed after start must not matter.
        begin_decode(4'd3);
        max_iter_cfg = 4'd1;
        expect_load("lim3_load");
        for (int it = 1; it <= 3; it++) begin
            expect_iter("lim3_it", it, 1'b0);
            report(1'b0);
        end
        expect_finish("lim3", 1'b0, 3);

        // cfg = 0 selects the default limit of 10.
        begin_decode(4'd0);
        expect_load("def_load");
        for (int it = 1; it <= 10; it++) begin
            expect_iter("def_it", it, 1'b0);
            report(1'b0);
        end
        expect_finish("def10", 1'b0, 10);

        // Stall in TEST, stray start / chk_valid pulses while busy.
        begin_decode(4'd2);
        start = 1'b1;
        expect_load("stall_load");
        start = 1'b0;
        expect_iter("stall_it1", 1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            start = (i % 3 == 0);
            cyc();
            chk("stall.busy", {31'd0, busy}, 32'd1);
            chk("stall.cnu_en", {31'd0, cnu_en}, 32'd0);
            chk("stall.out_en", {31'd0, out_en}, 32'd0);
            chk("stall.load_en", {31'd0, load_en}, 32'd0);
            chk("stall.iter_cnt", {28'd0, iter_cnt}, 32'd1);
        end
        start = 1'b0;
        report(1'b0);
        expect_iter("stall_it2", 2, 1'b0);
        report(1'b1);
        expect_finish("stall", 1'b1, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
